// File: rtl/board_pkg.sv
// Board-level constants shared by the memory-mapped peripherals:
// chip-select nibbles decoded from address_bus[15:12] and button port offsets.
package board_pkg;

  typedef enum logic [1:0] {
    REG_STATE = 2'd0,
    REG_RISE  = 2'd1,
    REG_FALL  = 2'd2,
    REG_MASK  = 2'd3
  } reg_sel_e;

  localparam logic [3:0] CS_LED    = 4'b1001;
  localparam logic [3:0] CS_BUTTON = 4'b1010;

endpackage

// File: rtl/button_port_if.sv
// CPU-side control strobes of a bus responder; the shared tristate data bus
// stays a plain inout on the responder itself.
interface button_port_if;
  logic [1:0] address;
  logic       cs;
  logic       write;
  logic       read;

  modport master (output address, cs, write, read);
  modport slave  (input  address, cs, write, read);
endinterface

// File: rtl/debounce_bit.sv
// One button: 2-flop synchronizer plus tick-driven stability counter.
// A new level is accepted on the STABLE-th consecutive differing tick.
module debounce_bit #(
  parameter int STABLE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic state,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [3:0] LAST = 4'(STABLE - 1);

  logic       meta;
  logic       sync;
  logic [3:0] cnt;
  logic       accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  assign accept = tick && (sync != state) && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (tick) begin
      if (sync == state) begin
        cnt <= '0;
      end else if (accept) begin
        state <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // Pulses coincide with the state update so the flag sets on the same edge.
  assign rise_pulse = accept &  sync;
  assign fall_pulse = accept & ~sync;

endmodule

// File: rtl/button_port.sv
// Memory-mapped button input port: debounced state, sticky W1C edge flags,
// per-bit irq mask and a registered level interrupt on the shared 8-bit bus.
module button_port
  import board_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1024,
  parameter int STABLE   = 4
) (
  input  logic             clk,
  input  logic             reset,
  button_port_if.slave     bus,
  inout  wire  [7:0]       data_bus,
  input  logic [WIDTH-1:0] buttons,
  output logic             irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [WIDTH-1:0] state_vec;
  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic             wr_en;
  logic [7:0]       rd;
  logic             unused_bus;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE(STABLE)) u_db (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .raw        (buttons[i]),
      .state      (state_vec[i]),
      .rise_pulse (rise_set[i]),
      .fall_pulse (fall_set[i])
    );
  end

  assign wr_en      = bus.cs & bus.write;
  assign wdata      = data_bus[WIDTH-1:0];
  assign unused_bus = ^data_bus;
  assign rise_clr   = (wr_en && bus.address == REG_RISE) ? wdata : '0;
  assign fall_clr   = (wr_en && bus.address == REG_FALL) ? wdata : '0;

  // Set is ORed in after the clear so an edge landing on a W1C is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= (rise & ~rise_clr) | rise_set;
      fall <= (fall & ~fall_clr) | fall_set;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask <= '0;
    end else if (wr_en && bus.address == REG_MASK) begin
      mask <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |((rise | fall) & mask);
    end
  end

  always_comb begin
    rd = '0;
    case (bus.address)
      REG_STATE: rd[WIDTH-1:0] = state_vec;
      REG_RISE:  rd[WIDTH-1:0] = rise;
      REG_FALL:  rd[WIDTH-1:0] = fall;
      REG_MASK:  rd[WIDTH-1:0] = mask;
      default:   rd = '0;
    endcase
  end

  assign data_bus = (bus.cs && bus.read) ? rd : 8'hzz;

endmodule

// File: tb/tb_button_port.sv
// Directed bench for button_port: an 8-bit and a 4-bit port on one shared bus,
// PRESCALE=4 and STABLE=4 so debounce timing is counted in bench cycles.
module tb_button_port;
  import board_pkg::*;

  localparam logic [3:0] CS_NARROW = 4'b1011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] abus = '0;
  logic        rd_s = 1'b0;
  logic        wr_s = 1'b0;
  logic        drv = 1'b0;
  logic [7:0]  wdata = '0;
  logic [7:0]  buttons = '0;
  logic [3:0]  buttons4 = '0;
  logic        irq;
  logic        irq4;
  wire  [7:0]  data_bus;
  int          cyc;
  int          n_chk = 0;
  int          n_pass = 0;
  int          j0;
  logic [7:0]  rv;

  always #5 clk = ~clk;

  assign data_bus = drv ? wdata : 8'hzz;

  button_port_if bus8 ();
  button_port_if bus4 ();

  assign bus8.address = abus[1:0];
  assign bus8.cs      = (abus[15:12] == CS_BUTTON);
  assign bus8.read    = rd_s;
  assign bus8.write   = wr_s;
  assign bus4.address = abus[1:0];
  assign bus4.cs      = (abus[15:12] == CS_NARROW);
  assign bus4.read    = rd_s;
  assign bus4.write   = wr_s;

  button_port #(.WIDTH(8), .PRESCALE(4), .STABLE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus8),
    .data_bus (data_bus),
    .buttons  (buttons),
    .irq      (irq)
  );

  button_port #(.WIDTH(4), .PRESCALE(4), .STABLE(4)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus4),
    .data_bus (data_bus),
    .buttons  (buttons4),
    .irq      (irq4)
  );

  // Edges since reset release; ticks land on edges where cyc % 4 == 0.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [15:0] a8(input logic [1:0] r);
    return {CS_BUTTON, 10'd0, r};
  endfunction

  function automatic logic [15:0] a4(input logic [1:0] r);
    return {CS_NARROW, 10'd0, r};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    abus  = a;
    wdata = d;
    drv   = 1'b1;
    wr_s  = 1'b1;
    @(posedge clk);
    #1;
    wr_s = 1'b0;
    drv  = 1'b0;
    abus = '0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    abus = a;
    rd_s = 1'b1;
    #1;
    d    = data_bus;
    rd_s = 1'b0;
    abus = '0;
  endtask

  task automatic check_reg(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  // Bench drives a pattern while reading an unselected address: any DUT drive corrupts it.
  task automatic check_float(input string tag, input logic [15:0] a);
    logic [7:0] d;
    wdata = 8'hA5;
    drv   = 1'b1;
    bus_read(a, d);
    drv   = 1'b0;
    check(tag, d, 8'hA5);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 200 && cyc < target; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4 && (cyc % 4) != 0; i++) begin
      @(posedge clk);
      #1;
    end
    j0 = cyc;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    buttons = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reg("rst_state", a8(REG_STATE), 8'h00);
    check_reg("rst_rise",  a8(REG_RISE),  8'h00);
    check_reg("rst_fall",  a8(REG_FALL),  8'h00);
    check_reg("rst_mask",  a8(REG_MASK),  8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check_float("rst_bus_z", 16'h0000);

    wait_cyc(15);
    check_reg("rst_state_t3", a8(REG_STATE), 8'h00);
    wait_cyc(16);
    check_reg("rst_state_t4", a8(REG_STATE), 8'hFF);
    check_reg("rst_rise_t4",  a8(REG_RISE),  8'hFF);
    bus_write(a8(REG_RISE), 8'hFF);
    check_reg("rise_clr_all", a8(REG_RISE), 8'h00);
    buttons = 8'h00;
    wait_n(24);
    check_reg("release_state", a8(REG_STATE), 8'h00);
    check_reg("release_fall",  a8(REG_FALL),  8'hFF);
    bus_write(a8(REG_FALL), 8'hFF);

    // Glitch of exactly three ticks is rejected.
    align;
    buttons = 8'h01;
    wait_cyc(j0 + 12);
    buttons = 8'h00;
    wait_n(16);
    check_reg("glitch_state", a8(REG_STATE), 8'h00);
    check_reg("glitch_rise",  a8(REG_RISE),  8'h00);

    align;
    buttons = 8'h01;
    wait_cyc(j0 + 15);
    check_reg("hold_state_t3", a8(REG_STATE), 8'h00);
    wait_cyc(j0 + 16);
    check_reg("hold_state_t4", a8(REG_STATE), 8'h01);
    check_reg("hold_rise",     a8(REG_RISE),  8'h01);
    bus_write(a8(REG_RISE), 8'h01);

    buttons = 8'h05;
    wait_n(24);
    check_reg("b2_rise", a8(REG_RISE), 8'h04);
    buttons = 8'h01;
    wait_n(24);
    check_reg("b2_fall",  a8(REG_FALL),  8'h04);
    check_reg("b2_state", a8(REG_STATE), 8'h01);
    bus_write(a8(REG_RISE), 8'h04);
    check_reg("w1c_rise", a8(REG_RISE), 8'h00);
    check_reg("w1c_fall_kept", a8(REG_FALL), 8'h04);
    bus_write(a8(REG_FALL), 8'h04);
    check_reg("w1c_fall", a8(REG_FALL), 8'h00);

    check_float("cs0_bus_z", {4'h0, 10'd0, REG_STATE});
    check_float("led_cs_bus_z", {CS_LED, 10'd0, REG_STATE});
    bus_write(a8(REG_STATE), 8'hFF);
    check_reg("state_ro", a8(REG_STATE), 8'h01);

    bus_write(a8(REG_MASK), 8'h00);
    buttons = 8'h03;
    wait_n(24);
    check_reg("b1_rise", a8(REG_RISE), 8'h02);
    check("irq_masked", {7'd0, irq}, 8'h00);
    bus_write(a8(REG_MASK), 8'h02);
    check("irq_mask_e0", {7'd0, irq}, 8'h00);
    wait_n(1);
    check("irq_mask_e1", {7'd0, irq}, 8'h01);
    check_reg("mask_rd", a8(REG_MASK), 8'h02);
    bus_write(a8(REG_RISE), 8'h02);
    check("irq_clr_e0", {7'd0, irq}, 8'h01);
    wait_n(1);
    check("irq_clr_e1", {7'd0, irq}, 8'h00);

    // Bit 5 qualifies on edge j0+16, the same edge the W1C is sampled.
    align;
    buttons = 8'h23;
    wait_cyc(j0 + 15);
    bus_write(a8(REG_RISE), 8'h20);
    check_reg("collide_rise",  a8(REG_RISE),  8'h20);
    check_reg("collide_state", a8(REG_STATE), 8'h23);

    bus_write(a4(REG_MASK), 8'hFF);
    check_reg("narrow_mask", a4(REG_MASK), 8'h0F);
    check("narrow_irq", {7'd0, irq4}, 8'h00);

    // Reset mid-debounce: held buttons re-qualify once from 0.
    align;
    buttons = 8'hA3;
    wait_n(6);
    apply_reset;
    #1;
    check_reg("mid_rst_state", a8(REG_STATE), 8'h00);
    check_reg("mid_rst_mask",  a8(REG_MASK),  8'h00);
    wait_cyc(15);
    check_reg("requal_t3", a8(REG_STATE), 8'h00);
    wait_cyc(16);
    check_reg("requal_state", a8(REG_STATE), 8'hA3);
    check_reg("requal_rise",  a8(REG_RISE),  8'hA3);
    wait_n(20);
    check_reg("requal_fall",  a8(REG_FALL),  8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/button_port.md
Name: button_port

Overview:
- Memory-mapped input peripheral: debounces up to 8 external buttons/switches, latches rising/falling edges and raises an interrupt.
- Read-direction counterpart of the LED output port. A bus responder on the shared 8-bit data bus, selected by a board-level chip select decoded from address_bus[15:12].
- Serves the CPU, which polls or takes irq and clears flags by write-1-to-clear.

Parameters:
- WIDTH, 8, number of inputs (1..8); unused data bits read 0.
- PRESCALE, 1024, clk cycles between debounce sample ticks (>=2).
- STABLE, 4, consecutive equal samples needed to accept a new level (1..15).

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- data_bus  inout  8  shared CPU data bus.
- address  in  2  register select (address_bus[1:0]).
- cs  in  1  chip select from board decode.
- write  in  1  CPU write strobe.
- read  in  1  CPU read strobe.
- buttons  in  WIDTH  raw asynchronous inputs, active-high.
- irq  out  1  level interrupt.

Behaviour:
- Reset (reset=0, asynchronous): sync flops, debounced state, counters, rise/fall flags, mask and prescaler all 0; irq=0; data_bus high-Z.
- Sync: each buttons bit passes through a 2-flop synchronizer before any use.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick is high for exactly one cycle when count = PRESCALE-1.
- Per-bit debounce, on tick only:
  - Synced sample equals state: stability counter cleared to 0.
  - Sample differs: counter increments.
  - When counter reaches STABLE-1 and the sample still differs: state <= sample, counter <= 0.
  - Net effect: a new level is accepted on the STABLE-th consecutive differing tick.
  - A glitch shorter than STABLE ticks never changes state.
- Edge capture:
  - state 0->1 sets rise[i]; 1->0 sets fall[i].
  - Flags are sticky until cleared.
- Register map (address):
  - 0 STATE: RO, debounced state.
  - 1 RISE: read flags; write 1s clears the corresponding bits.
  - 2 FALL: same semantics as RISE.
  - 3 MASK: RW irq enable per bit.
- Write:
  - Sampled on posedge clk when cs & write.
  - Writes to STATE are ignored.
  - MASK bits >= WIDTH are stored as 0.
- Read:
  - data_bus is driven combinationally with the selected register while cs & read; high-Z otherwise.
  - Reads have no side effects.
  - write and read never assert together. If they do, the write takes effect and data_bus is still driven.
- Simultaneous set and clear in the same cycle: set wins, so the flag stays 1 and no edge is lost.
- irq: registered; irq <= |((rise | fall) & mask). Asserts 1 cycle after a flag sets with its mask bit 1. Deasserts 1 cycle after the last enabled flag clears or the mask clears.
- Mask changes do not affect flags: flags latch regardless of mask.
- Reset mid-debounce discards partial counts. After release, the state re-qualifies from 0, so a held button produces one rise.

Decomposition:
- Shared package board_pkg holds:
  - register offsets REG_STATE=0, REG_RISE=1, REG_FALL=2, REG_MASK=3;
  - the chip-select nibble for this port, 4'b1010, alongside the existing ones.
- One sub-module, debounce_bit:
  - contents: synchronizer, stability counter, state;
  - inputs: clk, reset, tick, raw;
  - outputs: state, rise_pulse, fall_pulse.
  - Instantiated WIDTH times.
- The top holds the prescaler, flags, mask, bus decode and irq.

Test Plan:
- Reset: hold reset=0 with buttons=8'hFF, release -> all registers read 8'h00, irq=0, data_bus Z. After 4 ticks STATE reads 8'hFF and RISE reads 8'hFF.
- Debounce (PRESCALE=4, STABLE=4):
  - buttons[0] pulse of 3 ticks -> STATE stays 8'h00, RISE 8'h00.
  - Held 4 ticks -> STATE 8'h01 on the 4th tick, RISE 8'h01.
- Edges and W1C:
  - Press then release bit 2 -> RISE 8'h04, FALL 8'h04.
  - Write 8'h04 to RISE -> RISE 8'h00, FALL unchanged 8'h04.
- irq:
  - MASK=8'h00 with a press on bit 1 -> irq=0.
  - Write MASK=8'h02 -> irq=1 one cycle later.
  - W1C RISE=8'h02 -> irq=0 one cycle later.
- Collision: force a rise on bit 5 in the same cycle as a write of 8'h20 to RISE -> RISE reads 8'h20 afterwards.
- Bus hygiene:
  - With cs=0 and read=1 -> data_bus Z.
  - Write 8'hFF to STATE -> no change.
  - With WIDTH=4, MASK write 8'hFF reads 8'h0F.
